// File: rtl/instr_encoder_if.sv
// Field-bundle input, encoded-word output and error status of instr_encoder.
// The encoder takes the slave side; a producer/consumer takes the master side.
interface instr_encoder_if #(
    parameter int SEQ_W = 8,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [1:0]       op;
    logic [5:0]       funct;
    logic [3:0]       rn;
    logic [3:0]       rd;
    logic [11:0]      src2;
    logic [23:0]      imm24;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [SEQ_W-1:0] out_seq;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, cond, op, funct, rn, rd, src2, imm24, out_ready,
        input  in_ready, out_valid, out_instr, out_seq, err_pulse, err_cnt
    );

    modport slave (
        input  in_valid, cond, op, funct, rn, rd, src2, imm24, out_ready,
        output in_ready, out_valid, out_instr, out_seq, err_pulse, err_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs cond/Op/Funct/Rn/Rd/Src2/Imm24 into ARMv4 words behind a small FIFO.
// Illegal Op/Funct bundles are consumed, flagged and counted but never queued.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int SEQ_W = 8,
    parameter int ERR_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    instr_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      r_mem_instr [DEPTH];
    logic [SEQ_W-1:0] r_mem_seq   [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [SEQ_W-1:0] r_seq;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_err_pulse;

    logic        w_full;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_illegal;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_instr;

    // Ready looks only at the registered count, never at out_ready.
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_in_ready = rst_n & ~w_full;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_illegal  = (bus.op == 2'b11) |
                        ((bus.op == 2'b10) & ~bus.funct[5]);
    assign w_push     = w_accept & ~w_illegal;
    assign w_pop      = (r_count != '0) & bus.out_ready;

    always_comb begin
        w_instr = {bus.cond, bus.op, bus.funct,
                   bus.rn, bus.rd, bus.src2};
        if (bus.op == 2'b10) begin
            w_instr = {bus.cond, 2'b10, bus.funct[5:4], bus.imm24};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_instr;
            r_mem_seq[r_wr_ptr]   <= r_seq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_seq       <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_accept & w_illegal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_seq    <= r_seq + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_accept && w_illegal && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_instr = r_mem_instr[r_rd_ptr];
    assign bus.out_seq   = r_mem_seq[r_rd_ptr];
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder against a queue-based
// reference model; small SEQ_W/ERR_W so wrap and saturation are reachable.
module tb_instr_encoder;
    localparam int DEPTH = 2;
    localparam int SEQ_W = 2;
    localparam int ERR_W = 2;
    localparam int SEQ_MOD = 1 << SEQ_W;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.SEQ_W(SEQ_W), .ERR_W(ERR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_instr[$];
    int          q_seq[$];
    int          m_seq = 0;
    int          m_err = 0;
    bit          m_pulse = 1'b0;

    function automatic bit legal(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b11) return 1'b0;
        if (op == 2'b10) return f[5];
        return 1'b1;
    endfunction

    function automatic logic [31:0] enc(
        input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
        input logic [3:0] rn, input logic [3:0] rd,
        input logic [11:0] s2, input logic [23:0] i24);
        logic [31:0] w;
        if (op == 2'b10) begin
            w = {c, 2'b10, f[5:4], i24};
        end else begin
            w = {c, op, f, rn, rd, s2};
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] c,
                         input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rn, input logic [3:0] rd,
                         input logic [11:0] s2, input logic [23:0] i24,
                         input bit ordy);
        bus.in_valid  = v;
        bus.cond      = c;
        bus.op        = op;
        bus.funct     = f;
        bus.rn        = rn;
        bus.rd        = rd;
        bus.src2      = s2;
        bus.imm24     = i24;
        bus.out_ready = ordy;
    endtask

    task automatic drive_rand(input bit v, input bit ordy,
                              input bit only_legal);
        logic [1:0] op;
        logic [5:0] f;
        op = 2'($urandom_range(0, only_legal ? 2 : 3));
        f  = 6'($urandom);
        if (only_legal && op == 2'b10) f[5] = 1'b1;
        drive(v, 4'($urandom), op, f, 4'($urandom), 4'($urandom),
              12'($urandom), 24'($urandom), ordy);
    endtask

    task automatic check_model();
        bit exp_rdy;
        exp_rdy = rst_n && (q_instr.size() < DEPTH);
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(q_instr.size() != 0));
        if (q_instr.size() != 0) begin
            check("out_instr", 64'(bus.out_instr), 64'(q_instr[0]));
            check("out_seq", 64'(bus.out_seq), 64'(q_seq[0]));
        end
        check("err_pulse", 64'(bus.err_pulse), 64'(m_pulse));
        check("err_cnt", 64'(bus.err_cnt), 64'(m_err));
    endtask

    // One clock: check at negedge, then advance the model at posedge.
    task automatic cycle();
        bit acc;
        bit pop;
        bit leg;
        logic [31:0] w;
        @(negedge clk);
        check_model();
        acc = bus.in_valid && rst_n && (q_instr.size() < DEPTH);
        pop = (q_instr.size() != 0) && bus.out_ready;
        leg = legal(bus.op, bus.funct);
        w = enc(bus.cond, bus.op, bus.funct, bus.rn, bus.rd,
                bus.src2, bus.imm24);
        @(posedge clk);
        if (!rst_n) begin
            q_instr.delete();
            q_seq.delete();
            m_seq = 0;
            m_err = 0;
            m_pulse = 1'b0;
        end else begin
            if (pop) begin
                void'(q_instr.pop_front());
                void'(q_seq.pop_front());
            end
            m_pulse = acc && !leg;
            if (acc && leg) begin
                q_instr.push_back(w);
                q_seq.push_back(m_seq);
                m_seq = (m_seq + 1) % SEQ_MOD;
            end
            if (acc && !leg && m_err < ERR_MAX) m_err++;
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 4'h0, 2'b00, 6'h0, 4'h0, 4'h0, 12'h0, 24'h0, ordy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1'b0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        check("rst_err_pulse", 64'(bus.err_pulse), 64'd0);
        cycle();
        rst_n = 1'b1;
        #1;
        check("rdy_after_rst", 64'(bus.in_ready), 64'd1);

        // ADD R1,R2,#5
        drive(1'b1, 4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1);
        cycle();
        idle(1'b1);
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_instr", 64'(bus.out_instr), 64'hE2821005);
        check("add_seq", 64'(bus.out_seq), 64'd0);
        cycle();
        // LDR R3,[R4,#8]
        drive(1'b1, 4'hE, 2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b1);
        cycle();
        idle(1'b1);
        check("ldr_instr", 64'(bus.out_instr), 64'hE5943008);
        check("ldr_seq", 64'(bus.out_seq), 64'd1);
        cycle();
        // B +2, then an illegal branch with funct[5]=0
        drive(1'b1, 4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 12'h0, 24'h000002, 1'b1);
        cycle();
        check("b_instr", 64'(bus.out_instr), 64'hEA000002);
        check("b_seq", 64'(bus.out_seq), 64'd2);
        drive(1'b1, 4'hE, 2'b10, 6'b000000, 4'd0, 4'd0, 12'h0, 24'h000002, 1'b1);
        cycle();
        idle(1'b1);
        check("ill_pulse", 64'(bus.err_pulse), 64'd1);
        check("ill_cnt", 64'(bus.err_cnt), 64'd1);
        check("ill_nopush", 64'(bus.out_valid), 64'd0);
        cycle();
        check("ill_pulse_end", 64'(bus.err_pulse), 64'd0);
        drive(1'b1, 4'h0, 2'b00, 6'h0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b1);
        cycle();
        check("seq_kept", 64'(bus.out_seq), 64'd3);
        idle(1'b1);
        cycle();

        // Backpressure with a full FIFO
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1, 1'b0, 1'b1);
            cycle();
        end
        check("bp_full_rdy", 64'(bus.in_ready), 64'd0);
        check("bp_head0", 64'(bus.out_seq), 64'd0);
        drive_rand(1'b1, 1'b1, 1'b1);
        cycle();
        check("bp_head1", 64'(bus.out_seq), 64'd1);
        cycle();
        check("bp_head2", 64'(bus.out_seq), 64'd2);
        idle(1'b1);
        cycle();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Sequence wrap and error saturation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1, 1'b1, 1'b1);
            cycle();
            check("wrap_seq", 64'(bus.out_seq), 64'(i % SEQ_MOD));
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 2'b11, 6'h0, 4'h0, 4'h0, 12'h0, 24'h0, 1'b1);
            cycle();
            check("sat_cnt", 64'(bus.err_cnt), 64'((i < 3) ? i + 1 : 3));
        end

        // Reset with two words buffered
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1, 1'b0, 1'b1);
            cycle();
        end
        rst_n = 1'b0;
        drive_rand(1'b1, 1'b1, 1'b1);
        cycle();
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_err", 64'(bus.err_cnt), 64'd0);
        rst_n = 1'b1;
        drive_rand(1'b1, 1'b1, 1'b1);
        cycle();
        check("rst_mid_seq", 64'(bus.out_seq), 64'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive_rand($urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) != 0, 1'b0);
            cycle();
        end
        rst_n = 1'b1;
        idle(1'b1);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
